// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  // Controller states: normal flow, waiting on data memory, terminal halt.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // Maximum number of data-memory wait cycles before an error halt.
  localparam int TIMEOUT_DEFAULT = 255;

  // Width of the saturating stall counter.
  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: the EX load writes a register that the ID
// instruction is about to read. Register 0 is hardwired and never hazards.
module hazard_detect (
  input  logic       load_ex_i,
  input  logic [4:0] rw_ex_i,
  input  logic [4:0] ra1_id_i,
  input  logic [4:0] ra2_id_i,
  input  logic       use_ra1_id_i,
  input  logic       use_ra2_id_i,
  output logic       hazard_o
);

  logic match1;
  logic match2;

  // Per-operand match, then qualify with the load and a non-zero destination.
  always_comb begin
    match1   = use_ra1_id_i && (ra1_id_i == rw_ex_i);
    match2   = use_ra2_id_i && (ra2_id_i == rw_ex_i);
    hazard_o = load_ex_i && (rw_ex_i != 5'd0) && (match1 || match2);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: produces stage-register enables and flushes with
// priority HALT > memory stall > branch > load-use, tracks data-memory wait
// time with a timeout into HALT, and counts stalled cycles (saturating).
//
// Handshake: the MEM-stage access is outstanding while mem_req=1; the memory
// completes it in any cycle where mem_ready=1. A cycle with mem_req=1 and
// mem_ready=0 freezes the whole pipeline; the completing cycle itself runs
// normally (no extra bubble).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_ex,
  input  logic [4:0]       rw_ex,
  input  logic [4:0]       ra1_id,
  input  logic [4:0]       ra2_id,
  input  logic             use_ra1_id,
  input  logic             use_ra2_id,
  input  logic             branch_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output state_e           dbg_state_o
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STALL_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic hazard;
  logic mem_stall;

  hazard_detect u_hazard (
    .load_ex_i    (load_ex),
    .rw_ex_i      (rw_ex),
    .ra1_id_i     (ra1_id),
    .ra2_id_i     (ra2_id),
    .use_ra1_id_i (use_ra1_id),
    .use_ra2_id_i (use_ra2_id),
    .hazard_o     (hazard)
  );

  // Next-state, wait counter and output muxing, in priority order.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_err_d   = mem_err_q;
    en_pc       = 1'b1;
    en_if_id    = 1'b1;
    en_id_ex    = 1'b1;
    en_ex_mem   = 1'b1;
    en_mem_wb   = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    mem_stall   = (state_q != ST_HALT) && mem_req && !mem_ready;

    if (state_q == ST_HALT) begin
      en_pc     = 1'b0;
      en_if_id  = 1'b0;
      en_id_ex  = 1'b0;
      en_ex_mem = 1'b0;
      en_mem_wb = 1'b0;
    end else if (mem_stall) begin
      en_pc     = 1'b0;
      en_if_id  = 1'b0;
      en_id_ex  = 1'b0;
      en_ex_mem = 1'b0;
      en_mem_wb = 1'b0;
      if (state_q == ST_RUN) begin
        state_d = ST_MEM_WAIT;
        wait_d  = '0;
      end else if (wait_q == WAIT_LAST) begin
        state_d   = ST_HALT;
        mem_err_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      // RUN, or the MEM_WAIT cycle where the memory completes.
      if (branch_taken_ex) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (hazard) begin
        en_pc       = 1'b0;
        en_if_id    = 1'b0;
        flush_id_ex = 1'b1;
      end
      state_d = halt_req ? ST_HALT : ST_RUN;
    end

    stall_d = stall_q;
    if (!en_pc && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign mem_err     = mem_err_q;
  assign stall_count = stall_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle combinational
// vectors plus hand-written multi-cycle sequences (stalls, timeout, halt,
// reset abort, counter saturation). Built with TIMEOUT=4 and CNT_W=4.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  logic                clock;
  logic                reset;
  logic                load_ex;
  logic [4:0]          rw_ex;
  logic [4:0]          ra1_id;
  logic [4:0]          ra2_id;
  logic                use_ra1_id;
  logic                use_ra2_id;
  logic                branch_taken_ex;
  logic                mem_req;
  logic                mem_ready;
  logic                halt_req;
  logic                en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic                flush_if_id, flush_id_ex;
  logic                halted;
  logic                mem_err;
  logic [TB_CNT_W-1:0] stall_count;
  state_e              dbg_state;
  logic [7:0]          out_vec;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_q[$];

  pipe_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .load_ex         (load_ex),
    .rw_ex           (rw_ex),
    .ra1_id          (ra1_id),
    .ra2_id          (ra2_id),
    .use_ra1_id      (use_ra1_id),
    .use_ra2_id      (use_ra2_id),
    .branch_taken_ex (branch_taken_ex),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .halt_req        (halt_req),
    .en_pc           (en_pc),
    .en_if_id        (en_if_id),
    .en_id_ex        (en_id_ex),
    .en_ex_mem       (en_ex_mem),
    .en_mem_wb       (en_mem_wb),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .halted          (halted),
    .mem_err         (mem_err),
    .stall_count     (stall_count),
    .dbg_state_o     (dbg_state)
  );

  // {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex, halted}
  assign out_vec = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                    flush_if_id, flush_id_ex, halted};

  localparam logic [7:0] O_RUN  = 8'b11111_00_0;
  localparam logic [7:0] O_LU   = 8'b00111_01_0;
  localparam logic [7:0] O_BR   = 8'b11111_11_0;
  localparam logic [7:0] O_MEM  = 8'b00000_00_0;
  localparam logic [7:0] O_HALT = 8'b00000_00_1;

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       load_ex;
    logic [4:0] rw_ex;
    logic [4:0] ra1_id;
    logic [4:0] ra2_id;
    logic       use_ra1;
    logic       use_ra2;
    logic       branch;
    logic       mem_req;
    logic       mem_ready;
    logic       halt_req;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    load_ex = 0; rw_ex = 0; ra1_id = 0; ra2_id = 0;
    use_ra1_id = 0; use_ra2_id = 0; branch_taken_ex = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0;
  endtask

  task automatic drive_hazard();
    load_ex = 1; rw_ex = 5'd5; ra2_id = 5'd5; use_ra2_id = 1;
  endtask

  // Hold reset for two edges, release on a falling edge.
  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    set_idle();
    reset = 1'b0;
    #2;
    check("async_reset_out", out_vec, O_RUN);

    vecs[0]  = '{"idle",          0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 0, O_RUN};
    vecs[1]  = '{"lu_ra2",        1, 5'd5,  5'd0,  5'd5,  0, 1, 0, 0, 0, 0, O_LU};
    vecs[2]  = '{"lu_ra1",        1, 5'd5,  5'd5,  5'd0,  1, 0, 0, 0, 0, 0, O_LU};
    vecs[3]  = '{"ra1_unused",    1, 5'd5,  5'd5,  5'd0,  0, 0, 0, 0, 0, 0, O_RUN};
    vecs[4]  = '{"rw_zero",       1, 5'd0,  5'd0,  5'd0,  1, 1, 0, 0, 0, 0, O_RUN};
    vecs[5]  = '{"not_load",      0, 5'd5,  5'd5,  5'd5,  1, 1, 0, 0, 0, 0, O_RUN};
    vecs[6]  = '{"branch_over_lu",1, 5'd5,  5'd5,  5'd0,  1, 0, 1, 0, 0, 0, O_BR};
    vecs[7]  = '{"mem_over_br",   1, 5'd5,  5'd5,  5'd0,  1, 0, 1, 1, 0, 0, O_MEM};
    vecs[8]  = '{"mem_ready_lu",  1, 5'd5,  5'd0,  5'd5,  0, 1, 0, 1, 1, 0, O_LU};
    vecs[9]  = '{"halt_req_run",  0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 1, O_RUN};
    vecs[10] = '{"lu_r31",        1, 5'd31, 5'd3,  5'd31, 1, 1, 0, 0, 0, 0, O_LU};

    // Reset state
    do_reset();
    #1;
    check("rst_out", out_vec, O_RUN);
    check("rst_stall_count", stall_count, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_state", dbg_state, ST_RUN);

    // Table: inputs applied between edges; idle again before each rising edge.
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      load_ex = vecs[i].load_ex; rw_ex = vecs[i].rw_ex;
      ra1_id = vecs[i].ra1_id; ra2_id = vecs[i].ra2_id;
      use_ra1_id = vecs[i].use_ra1; use_ra2_id = vecs[i].use_ra2;
      branch_taken_ex = vecs[i].branch; mem_req = vecs[i].mem_req;
      mem_ready = vecs[i].mem_ready; halt_req = vecs[i].halt_req;
      exp_q.push_back(vecs[i].exp_out);
      #1;
      check(vecs[i].name, out_vec, exp_q.pop_front());
      #1;
      set_idle();
    end
    check("table_state_run", dbg_state, ST_RUN);
    check("table_no_stall", stall_count, 0);

    // Load-use: one stall cycle, counted once.
    do_reset();
    drive_hazard();
    #1;
    check("lu_out", out_vec, O_LU);
    cyc();
    check("lu_count", stall_count, 1);
    set_idle();
    #1;
    check("lu_released", out_vec, O_RUN);
    cyc();
    check("lu_count_hold", stall_count, 1);

    // Same hazard with a taken branch: flush, no stall.
    do_reset();
    drive_hazard();
    branch_taken_ex = 1;
    #1;
    check("br_out", out_vec, O_BR);
    cyc();
    check("br_count", stall_count, 0);
    set_idle();

    // Memory stall for three cycles, then ready.
    do_reset();
    mem_req = 1; mem_ready = 0;
    #1;
    check("mw_c1", out_vec, O_MEM);
    cyc();
    check("mw_state", dbg_state, ST_MEM_WAIT);
    check("mw_c2", out_vec, O_MEM);
    cyc();
    check("mw_c3", out_vec, O_MEM);
    cyc();
    mem_ready = 1;
    #1;
    check("mw_ready_out", out_vec, O_RUN);
    cyc();
    check("mw_count", stall_count, 3);
    check("mw_back_run", dbg_state, ST_RUN);
    set_idle();

    // Timeout: 4 wait cycles in MEM_WAIT, then HALT; then saturation.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (4) cyc();
    check("to_not_yet", halted, 0);
    check("to_count4", stall_count, 4);
    cyc();
    check("to_halted", out_vec, O_HALT);
    check("to_mem_err", mem_err, 1);
    check("to_count5", stall_count, 5);
    set_idle();
    mem_ready = 1;
    #1;
    check("to_halt_sticky_out", out_vec, O_HALT);
    repeat (12) cyc();
    check("sat_max", stall_count, 15);
    cyc();
    check("sat_no_wrap", stall_count, 15);
    check("halt_stays", dbg_state, ST_HALT);

    // Halt request deferred behind a memory stall; then async reset in HALT.
    do_reset();
    mem_req = 1; mem_ready = 0; halt_req = 1;
    cyc();
    cyc();
    check("hr_deferred", halted, 0);
    check("hr_state_mw", dbg_state, ST_MEM_WAIT);
    mem_ready = 1;
    #1;
    check("hr_ready_out", out_vec, O_RUN);
    cyc();
    check("hr_halted", halted, 1);
    set_idle();
    #2;
    reset = 1'b0;
    #1;
    check("hr_rst_out", out_vec, O_RUN);
    check("hr_rst_count", stall_count, 0);
    check("hr_rst_state", dbg_state, ST_RUN);

    // Async reset in the middle of MEM_WAIT, then a fresh full timeout.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (3) cyc();
    #2;
    reset = 1'b0;
    #1;
    check("mwr_state", dbg_state, ST_RUN);
    check("mwr_count", stall_count, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) cyc();
    check("mwr_full_wait", halted, 0);
    cyc();
    check("mwr_timeout", halted, 1);
    check("mwr_mem_err", mem_err, 1);
    set_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of data-memory wait cycles before an error halt.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-003 The block SHALL use one clock, and reset SHALL be asynchronous and active-low, with ports named clock and reset.
REQ-004 clock  input  1  pipeline clock; all state is updated on the rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 load_ex  input  1  the instruction in EX is a load.
REQ-007 rw_ex  input  5  destination register of the EX instruction.
REQ-008 ra1_id, ra2_id  input  5 each  source registers of the ID instruction.
REQ-009 use_ra1_id, use_ra2_id  input  1 each  the ID instruction reads ra1 / ra2.
REQ-010 branch_taken_ex  input  1  taken branch or jump resolved in EX.
REQ-011 mem_req, mem_ready  input  1 each  the MEM-stage access is pending / the memory returns ready.
REQ-012 halt_req  input  1  software halt request (RSA routine done).
REQ-013 en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  output  1 each  stage-register load enables.
REQ-014 flush_if_id, flush_id_ex  output  1 each  the stage register loads a bubble (wr_en=0) this edge.
REQ-015 halted  output  1  the controller is in HALT.
REQ-016 mem_err  output  1  sticky memory-timeout flag.
REQ-017 stall_count  output  CNT_W  saturating count of cycles with en_pc=0.

Function
REQ-018 States SHALL be RUN, MEM_WAIT and HALT, encoded as an enum in the package.
REQ-019 A load-use hazard SHALL be defined as: load_ex=1, rw_ex!=0, and (use_ra1_id and ra1_id==rw_ex, or use_ra2_id and ra2_id==rw_ex).
REQ-020 Outputs SHALL be combinational from state and current inputs (zero-cycle response), with priority HALT > memory stall > branch > load-use.
REQ-021 Default in RUN: all enables=1, flushes=0.
REQ-022 Memory stall (any state except HALT, mem_req=1, mem_ready=0): all five enables=0, flushes=0; RUN->MEM_WAIT.
REQ-023 MEM_WAIT with mem_ready=1: the RUN outputs SHALL apply in the same cycle (branch/load-use are evaluated normally); next state RUN.
REQ-024 The wait counter SHALL clear on entering MEM_WAIT and increment each MEM_WAIT cycle with mem_ready=0; if it reaches TIMEOUT-1 with mem_ready=0, the next state is HALT and mem_err is set.
REQ-025 Branch (branch_taken_ex=1, no memory stall): enables=1, flush_if_id=1, flush_id_ex=1; the load-use condition is ignored that cycle.
REQ-026 Load-use (no branch, no memory stall): en_pc=0, en_if_id=0, flush_id_ex=1, and all other enables=1; this lasts exactly one cycle because the load advances to MEM.
REQ-027 halt_req=1 in RUN SHALL take effect only when no memory stall exists; the next state is HALT.
REQ-028 HALT: all enables=0, flushes=0, halted=1; HALT is left only by reset.
REQ-029 stall_count SHALL increment on every edge where en_pc=0, including in HALT, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-030 rw_ex=0 SHALL never produce a load-use stall.

Reset
REQ-031 While reset=0: state=RUN, wait counter=0, mem_err=0, stall_count=0; outputs follow RUN defaults (halted=0).
REQ-032 Reset asserted mid-MEM_WAIT or in HALT SHALL abort immediately (asynchronously); no pending count survives.

Structure
REQ-033 Package pipe_ctrl_pkg SHALL hold the state enum and the TIMEOUT_DEFAULT and CNT_W_DEFAULT constants.
REQ-034 One combinational sub-module, hazard_detect, SHALL implement the REQ-019 compare; the FSM, counters and output muxing are in pipe_ctrl.

Verification
REQ-035 load_ex=1, rw_ex=5, ra2_id=5, use_ra2_id=1 -> for 1 cycle en_pc=0, en_if_id=0, flush_id_ex=1; stall_count=1.
REQ-036 Same stimulus with branch_taken_ex=1 -> flush_if_id=1, flush_id_ex=1, en_pc=1, stall_count unchanged.
REQ-037 mem_req=1, mem_ready low for 3 cycles then high -> enables 0 for 3 cycles, 1 on the ready cycle, stall_count=3, state RUN.
REQ-038 TIMEOUT=4, mem_ready held low -> HALT after 4 wait cycles, mem_err=1, halted=1, enables stay 0.
REQ-039 halt_req during a memory stall -> HALT is deferred until mem_ready=1; reset=0 in HALT -> all registers clear and en_pc=1.
REQ-040 Force stall_count to 2^CNT_W-1, then stall -> the value holds and does not wrap.
